// File: rtl/serial_parallel_pkg.sv
// Shared types and the bit-order shift helper for the serial-to-parallel deserializer.
package serial_parallel_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_FULL
  } out_state_e;

  localparam int unsigned MaxWidth = 64;

  // Operates on a MaxWidth-wide container; callers keep only the low `width` bits.
  function automatic logic [MaxWidth-1:0] shift_in_bit(input logic [MaxWidth-1:0] cur,
                                                       input logic                bit_in,
                                                       input logic                msb_first,
                                                       input int unsigned         width);
    logic [MaxWidth-1:0] res;
    if (msb_first) begin
      res = {cur[MaxWidth-2:0], bit_in};
    end else begin
      res = (cur >> 1) | ({{(MaxWidth-1){1'b0}}, bit_in} << (width - 1));
    end
    return res;
  endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Shift register and bit counter with frame resynchronisation; flags each completed word.
module deser_shift_core
  import serial_parallel_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_sync,
  output logic             word_done,
  output logic [WIDTH-1:0] word_data,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    shift_base;
  logic [MaxWidth-1:0] unused_shift_wide;

  // A sync restarts the word, so the incoming bit shifts into an all-zero register.
  assign shift_base        = frame_sync ? '0 : shift_q;
  assign unused_shift_wide = shift_in_bit(MaxWidth'(shift_base), serial_in, MSB_FIRST, WIDTH);

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (frame_sync) begin
      if (serial_valid) begin
        shift_d = unused_shift_wide[WIDTH-1:0];
        cnt_d   = CW'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (serial_valid) begin
      shift_d = unused_shift_wide[WIDTH-1:0];
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_data = shift_d;
  assign bit_count = cnt_q;

endmodule

// File: rtl/serial_parallel_deser.sv
// Serial-to-parallel deserializer: registered word output with valid/ready and sticky overrun.
module serial_parallel_deser
  import serial_parallel_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  input  logic             clear_overrun
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic [WIDTH-1:0] word_data;

  deser_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_sync   (frame_sync),
    .word_done    (word_done),
    .word_data    (word_data),
    .bit_count    (bit_count)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    overrun_d = overrun_q;
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    unique case (state_q)
      ST_EMPTY: begin
        if (word_done) begin
          out_d   = word_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          // Back-to-back handshake and completion reloads without a bubble.
          if (word_done) begin
            out_d = word_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (word_done) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = out_q;
  assign out_valid    = (state_q == ST_FULL);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_serial_parallel_deser.sv
// Scoreboarded bench: stimulus pushes expected words, a negedge monitor checks each handshake.
module tb_serial_parallel_deser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_overrun = 1'b0;

  logic [7:0] parallel_out, lsb_out;
  logic       out_valid, lsb_valid;
  logic [2:0] bit_count, lsb_count;
  logic       overrun, lsb_overrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  serial_parallel_deser #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .frame_sync    (frame_sync),
    .parallel_out  (parallel_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .bit_count     (bit_count),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  serial_parallel_deser #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .serial_valid  (serial_valid),
    .frame_sync    (frame_sync),
    .parallel_out  (lsb_out),
    .out_valid     (lsb_valid),
    .out_ready     (out_ready),
    .bit_count     (lsb_count),
    .overrun       (lsb_overrun),
    .clear_overrun (clear_overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w[hi] down to w[lo], one bit per edge, serial_valid held across the run.
  task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      serial_in    = w[i];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {56'd0, parallel_out}, 64'hDEAD);
      end else begin
        check("scoreboard_word", {56'd0, parallel_out}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] t1;
    t1 = 8'hA5;

    tick();
    tick();
    check("rst_parallel_out", {56'd0, parallel_out}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_bit_count", {61'd0, bit_count}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    reset = 1'b1;

    // 1: MSB-first A5 with bit_count trace
    out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      serial_in    = t1[i];
      serial_valid = 1'b1;
      tick();
      check("t1_bit_count", {61'd0, bit_count}, 64'((8 - i) % 8));
    end
    serial_valid = 1'b0;
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_word", {56'd0, parallel_out}, 64'hA5);
    check("t2_lsb_palindrome", {56'd0, lsb_out}, 64'hA5);
    tick();
    check("t1_valid_pulse", {63'd0, out_valid}, 64'd0);

    // 2: LSB-first 1,1,0,0,0,0,0,0 -> 03; MSB-first view is C0
    exp_q.push_back(8'hC0);
    send_bits(8'hC0, 7, 0);
    check("t2_lsb_word", {56'd0, lsb_out}, 64'h03);
    check("t2_msb_word", {56'd0, parallel_out}, 64'hC0);
    tick();

    // 3: overrun with consumer stalled
    out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 7, 0);
    check("t3_first_valid", {63'd0, out_valid}, 64'd1);
    send_bits(8'hFF, 7, 0);
    check("t3_held_word", {56'd0, parallel_out}, 64'h3C);
    check("t3_overrun_set", {63'd0, overrun}, 64'd1);
    check("t3_still_valid", {63'd0, out_valid}, 64'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("t3_overrun_cleared", {63'd0, overrun}, 64'd0);
    send_bits(8'h00, 7, 1);
    clear_overrun = 1'b1;
    send_bits(8'h00, 0, 0);
    clear_overrun = 1'b0;
    check("t3_set_wins", {63'd0, overrun}, 64'd1);
    check("t3_held_word2", {56'd0, parallel_out}, 64'h3C);
    out_ready = 1'b1;
    tick();
    check("t3_drained", {63'd0, out_valid}, 64'd0);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;

    // 4: continuous stream, no drops
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send_bits(8'h11, 7, 0);
    check("t4_w11", {56'd0, parallel_out}, 64'h11);
    send_bits(8'h22, 7, 0);
    check("t4_w22", {56'd0, parallel_out}, 64'h22);
    send_bits(8'h33, 7, 0);
    check("t4_w33", {56'd0, parallel_out}, 64'h33);
    check("t4_no_overrun", {63'd0, overrun}, 64'd0);
    tick();

    // 5: frame_sync mid-word realigns
    send_bits(8'hFF, 7, 3);
    check("t5_partial_count", {61'd0, bit_count}, 64'd5);
    exp_q.push_back(8'hC3);
    serial_in    = 1'b1;
    serial_valid = 1'b1;
    frame_sync   = 1'b1;
    tick();
    frame_sync   = 1'b0;
    serial_valid = 1'b0;
    check("t5_sync_count", {61'd0, bit_count}, 64'd1);
    check("t5_no_early_valid", {63'd0, out_valid}, 64'd0);
    send_bits(8'hC3, 6, 0);
    check("t5_word", {56'd0, parallel_out}, 64'hC3);
    tick();

    // 6: reset mid-word with pending output and overrun
    out_ready = 1'b0;
    send_bits(8'h5A, 7, 0);
    send_bits(8'h77, 7, 0);
    send_bits(8'hE0, 7, 5);
    check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    check("t6_pre_overrun", {63'd0, overrun}, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_rst_word", {56'd0, parallel_out}, 64'd0);
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_count", {61'd0, bit_count}, 64'd0);
    check("t6_rst_overrun", {63'd0, overrun}, 64'd0);
    out_ready = 1'b1;
    exp_q.push_back(8'h96);
    send_bits(8'h96, 7, 0);
    check("t6_fresh_word", {56'd0, parallel_out}, 64'h96);
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
